// File: rtl/cpu_run_ctl.sv
// cpu_run_ctl: run/halt/boot FSM with timed boot_clear, held interrupt request and boot counter.
// Single-step support is compiled in only when CPU_SINGLE_STEP_EN is defined.
module cpu_run_ctl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic             boot,
    input  logic             halt,
    input  logic             interrupt,
    input  logic             step_req,
    input  logic             cpu_err,
    input  logic             int_ack,
    output logic             run,
    output logic             boot_clear,
    output logic             int_pending,
    output logic             step_done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] boot_count
);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_BOOT   = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t     cur_state;
    logic       boot_q;
    logic       int_q;
    logic       booted;
    logic [7:0] boot_cnt;
    logic       boot_rise;
    logic       int_rise;
    logic       step_go;

    assign boot_rise = boot & ~boot_q;
    assign int_rise  = interrupt & ~int_q;

`ifdef CPU_SINGLE_STEP_EN
    assign step_go = step_req;
`else
    logic unused_step_req;
    assign unused_step_req = step_req;
    assign step_go         = 1'b0;
`endif

    assign state      = cur_state;
    assign run        = (cur_state == S_RUN) || (cur_state == S_STEP);
    assign boot_clear = (cur_state == S_BOOT);

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            cur_state   <= S_HALTED;
            boot_q      <= 1'b0;
            int_q       <= 1'b0;
            booted      <= 1'b0;
            boot_cnt    <= '0;
            boot_count  <= '0;
            int_pending <= 1'b0;
            step_done   <= 1'b0;
        end else begin
            boot_q    <= boot;
            int_q     <= interrupt;
            step_done <= 1'b0;

            if (boot_rise) begin
                cur_state <= S_BOOT;
                boot_cnt  <= 8'(BOOT_CYCLES - 1);
                if (boot_count != '1)
                    boot_count <= boot_count + 1'b1;
            end else begin
                case (cur_state)
                    S_BOOT: begin
                        if (boot_cnt == '0) begin
                            booted    <= 1'b1;
                            cur_state <= halt ? S_HALTED : S_RUN;
                        end else begin
                            boot_cnt <= boot_cnt - 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (cpu_err)
                            cur_state <= S_ERR;
                        else if (halt)
                            cur_state <= S_HALTED;
                    end
                    S_HALTED: begin
                        // A step request wins over a held halt; that is what single-step is for.
                        if (step_go)
                            cur_state <= S_STEP;
                        else if (!halt && booted)
                            cur_state <= S_RUN;
                    end
`ifdef CPU_SINGLE_STEP_EN
                    S_STEP: begin
                        if (cpu_err) begin
                            cur_state <= S_ERR;
                        end else begin
                            cur_state <= S_HALTED;
                            step_done <= 1'b1;
                        end
                    end
`endif
                    S_ERR:   cur_state <= S_ERR;
                    default: cur_state <= S_HALTED;
                endcase
            end

            // Boot edge flushes any held request, even one arriving in the same cycle.
            if (boot_rise)
                int_pending <= 1'b0;
            else if (int_rise)
                int_pending <= 1'b1;
            else if (int_ack)
                int_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Self-checking bench for cpu_run_ctl: directed scenarios plus random stimulus against a behavioural model.
module tb_cpu_run_ctl;

    localparam int unsigned BOOT_CYCLES = 4;
    localparam int unsigned CNT_W       = 8;
`ifdef CPU_SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic             cpu_clk = 1'b0;
    logic             reset;
    logic             boot, halt, interrupt, step_req, cpu_err, int_ack;
    logic             run, boot_clear, int_pending, step_done;
    logic [2:0]       state;
    logic [CNT_W-1:0] boot_count;
    logic [14:0]      dut_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state;
    int m_boot_left;
    int m_count;
    bit m_booted, m_pend, m_sdone, m_boot_prev, m_int_prev;

    cpu_run_ctl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .boot        (boot),
        .halt        (halt),
        .interrupt   (interrupt),
        .step_req    (step_req),
        .cpu_err     (cpu_err),
        .int_ack     (int_ack),
        .run         (run),
        .boot_clear  (boot_clear),
        .int_pending (int_pending),
        .step_done   (step_done),
        .state       (state),
        .boot_count  (boot_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign dut_vec = {state, run, boot_clear, int_pending, step_done, boot_count};

    function automatic logic [14:0] exp_vec();
        logic [7:0] c;
        logic       r, bc;
        c  = m_count[7:0];
        r  = (m_state == 2) || (m_state == 3);
        bc = (m_state == 1);
        return {3'(m_state), r, bc, m_pend, m_sdone, c};
    endfunction

    task automatic model_reset();
        m_state = 0; m_boot_left = 0; m_count = 0;
        m_booted = 0; m_pend = 0; m_sdone = 0; m_boot_prev = 0; m_int_prev = 0;
    endtask

    // boot_left counts BOOT cycles still owed, including the current one.
    task automatic model_edge();
        bit be, ie, sd;
        int ns;
        be = boot && !m_boot_prev;
        ie = interrupt && !m_int_prev;
        ns = m_state;
        sd = 0;
        if (be) begin
            ns = 1;
            m_boot_left = BOOT_CYCLES;
            if (m_count < 255) m_count++;
        end else begin
            case (m_state)
                1: begin
                    m_boot_left--;
                    if (m_boot_left == 0) begin
                        m_booted = 1;
                        ns = halt ? 0 : 2;
                    end
                end
                2: if (cpu_err) ns = 4; else if (halt) ns = 0;
                0: if (STEP_EN && step_req) ns = 3; else if (!halt && m_booted) ns = 2;
                3: if (cpu_err) ns = 4; else begin ns = 0; sd = 1; end
                default: ;
            endcase
        end
        if (be) m_pend = 0;
        else if (ie) m_pend = 1;
        else if (int_ack) m_pend = 0;
        m_state = ns;
        m_sdone = sd;
        m_boot_prev = boot;
        m_int_prev = interrupt;
    endtask

    task automatic tick(input logic b, input logic h, input logic i,
                        input logic s, input logic e, input logic a);
        boot = b; halt = h; interrupt = i; step_req = s; cpu_err = e; int_ack = a;
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        boot = 0; halt = 0; interrupt = 0; step_req = 0; cpu_err = 0; int_ack = 0;
        model_reset();
        #2;
        checks++;
        if (dut_vec !== 15'd0) begin
            errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, 15'd0);
        end
        repeat (2) @(posedge cpu_clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL idle_after_reset[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
            checks++;
            if (state !== 3'd0 || run !== 1'b0) begin
                errors++; $display("FAIL never_runs_unbooted[%0d]: state %0d run %b expected 0/0", i, state, run);
            end
        end
    endtask

    task automatic test_boot();
        int bc_cycles;
        bc_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            if (boot_clear === 1'b1) bc_cycles++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL boot_seq[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (bc_cycles != BOOT_CYCLES) begin
            errors++; $display("FAIL boot_clear_len: got %0d expected %0d", bc_cycles, BOOT_CYCLES);
        end
        checks++;
        if (run !== 1'b1 || boot_count !== 8'd1) begin
            errors++; $display("FAIL boot_done: run %b count %0d expected 1/1", run, boot_count);
        end
        repeat (2) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_halt();
        tick(0, 1, 0, 0, 0, 0);
        checks++;
        if (run !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL halt_stops: run %b state %0d expected 0/0", run, state);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (run !== 1'b1 || state !== 3'd2) begin
            errors++; $display("FAIL halt_release: run %b state %0d expected 1/2", run, state);
        end
    endtask

    task automatic test_step();
        int runs, dones;
        runs = 0; dones = 0;
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        if (run === 1'b1) runs++;
        if (step_done === 1'b1) dones++;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            if (run === 1'b1) runs++;
            if (step_done === 1'b1) dones++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL step_seq[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (runs != (STEP_EN ? 1 : 0) || dones != (STEP_EN ? 1 : 0)) begin
            errors++; $display("FAIL step_pulses: run %0d done %0d expected %0d/%0d",
                               runs, dones, STEP_EN ? 1 : 0, STEP_EN ? 1 : 0);
        end
    endtask

    task automatic test_err();
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if (state !== 3'd4 || run !== 1'b0) begin
            errors++; $display("FAIL err_entry: state %0d run %b expected 4/0", state, run);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, logic'(i % 2), 0, 1, 0, 0);
            checks++;
            if (state !== 3'd4) begin
                errors++; $display("FAIL err_sticky[%0d]: state %0d expected 4", i, state);
            end
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'd1 || boot_count !== 8'd2) begin
            errors++; $display("FAIL err_reboot: state %0d count %0d expected 1/2", state, boot_count);
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL err_reboot_seq[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_int();
        logic [5:0] seq [9];
        logic       want [9];
        // {boot, interrupt, int_ack} per step and required int_pending afterwards
        seq = '{6'b000, 6'b010, 6'b000, 6'b011, 6'b001, 6'b010, 6'b100, 6'b000, 6'b110};
        want = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            tick(seq[i][2], 0, seq[i][1], 0, 0, seq[i][0]);
            checks++;
            if (int_pending !== want[i] || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL int_seq[%0d]: pending %b vec %h expected %b vec %h",
                                   i, int_pending, dut_vec, want[i], exp_vec());
            end
        end
        repeat (5) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic h;
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) h = ~h;
            tick(logic'($urandom_range(0, 19) == 0), h, logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 14) == 0),
                 logic'($urandom_range(0, 2) == 0));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_boot();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (boot_clear !== 1'b1) begin
            errors++; $display("FAIL mid_boot_setup: boot_clear %b expected 1", boot_clear);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 15'd0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, 15'd0);
        end
        model_reset();
        boot = 1'b0;
        @(posedge cpu_clk);
        #1 reset = 1'b0;
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL after_reset: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_boot();
        test_halt();
        test_step();
        test_err();
        test_int();
        test_random();
        test_reset_mid_boot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
